// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of one BRAM port (read latency 1).
// Round-robin between s0/s1, lockable grant for read-modify-write with a
// watchdog that breaks stale locks, and read data routed back to the
// requester that issued the read.
module bram_port_arbiter #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_LOCK_TIMEOUT = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s0_valid,
  output logic                      s0_ready,
  input  logic [C_ADDR_WIDTH-1:0]   s0_addr,
  input  logic [C_DATA_WIDTH-1:0]   s0_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s0_we,
  input  logic                      s0_lock,
  output logic                      s0_rvalid,
  output logic [C_DATA_WIDTH-1:0]   s0_rdata,
  input  logic                      s1_valid,
  output logic                      s1_ready,
  input  logic [C_ADDR_WIDTH-1:0]   s1_addr,
  input  logic [C_DATA_WIDTH-1:0]   s1_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s1_we,
  input  logic                      s1_lock,
  output logic                      s1_rvalid,
  output logic [C_DATA_WIDTH-1:0]   s1_rdata,
  output logic                      m_en,
  output logic [C_DATA_WIDTH/8-1:0] m_we,
  output logic [C_ADDR_WIDTH-1:0]   m_addr,
  output logic [C_DATA_WIDTH-1:0]   m_din,
  input  logic [C_DATA_WIDTH-1:0]   m_dout,
  output logic                      lock_timeout
);

  localparam int WE_W = C_DATA_WIDTH / 8;
  localparam int WD_W = ($clog2(C_LOCK_TIMEOUT) < 1) ? 1 : $clog2(C_LOCK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(C_LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rpend_q, rpend_d;
  logic            rsel_q, rsel_d;
  // run_q stays low through reset and for the release edge, so grants are
  // gated by a register and nothing can transfer while aresetn is low.
  logic            run_q, run_d;

  logic gnt0, gnt1, xfer, xfer_read, sel1, expire;

  // State register and all control flops; async clear, sync release via run_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      wd_q    <= '0;
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      wd_q    <= wd_d;
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
      run_q   <= run_d;
    end
  end

  // Grant selection, lock FSM next state and watchdog.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    expire  = 1'b0;
    state_d = state_q;
    wd_d    = wd_q;
    run_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        gnt0 = run_q & s0_valid & (~s1_valid | ~prio_q);
        gnt1 = run_q & s1_valid & (~s0_valid |  prio_q);
        wd_d = '0;
        if (gnt0 && s0_lock)      state_d = ST_LOCK0;
        else if (gnt1 && s1_lock) state_d = ST_LOCK1;
      end
      ST_LOCK0: begin
        // An owner transfer always wins over the watchdog.
        gnt0 = run_q & s0_valid;
        if (gnt0) begin
          wd_d = '0;
          if (!s0_lock) state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_LOCK1: begin
        gnt1 = run_q & s1_valid;
        if (gnt1) begin
          wd_d = '0;
          if (!s1_lock) state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wd_d    = '0;
      end
    endcase
  end

  // Priority pointer, read-return bookkeeping and BRAM port drive.
  always_comb begin
    xfer      = gnt0 | gnt1;
    xfer_read = gnt0 ? ~|s0_we : ~|s1_we;
    prio_d    = gnt0 ? 1'b1 : (gnt1 ? 1'b0 : prio_q);
    rpend_d   = xfer & xfer_read;
    rsel_d    = (xfer && xfer_read) ? gnt1 : rsel_q;
    // With no grant, the address/data mux parks on the prio requester.
    sel1      = gnt1 | (~gnt0 & prio_q);
    m_en      = xfer;
    m_we      = gnt0 ? s0_we : (gnt1 ? s1_we : {WE_W{1'b0}});
    m_addr    = sel1 ? s1_addr  : s0_addr;
    m_din     = sel1 ? s1_wdata : s0_wdata;
    s0_ready  = gnt0;
    s1_ready  = gnt1;
    lock_timeout = expire;
    s0_rvalid = rpend_q & ~rsel_q;
    s1_rvalid = rpend_q &  rsel_q;
    s0_rdata  = m_dout;
    s1_rdata  = m_dout;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a byte-write read-first BRAM model
// and a per-requester read-return scoreboard.
module tb_bram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int WW = DW / 8;
  localparam int TO = 16;

  logic          aclk, aresetn;
  logic          s0_valid, s0_ready, s0_lock, s0_rvalid;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_wdata, s0_rdata;
  logic [WW-1:0] s0_we;
  logic          s1_valid, s1_ready, s1_lock, s1_rvalid;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_wdata, s1_rdata;
  logic [WW-1:0] s1_we;
  logic          m_en, lock_timeout;
  logic [WW-1:0] m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout;

  bram_port_arbiter #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_LOCK_TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_we(s0_we), .s0_lock(s0_lock), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_we(s1_we), .s1_lock(s1_lock), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout),
    .lock_timeout(lock_timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // BRAM model: 4 words, read-first, byte write enables, latency 1.
  logic [DW-1:0] mem [4];
  always @(posedge aclk) begin
    if (m_en) begin
      m_dout <= mem[m_addr[3:2]];
      for (int b = 0; b < WW; b++)
        if (m_we[b]) mem[m_addr[3:2]][b*8 +: 8] <= m_din[b*8 +: 8];
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_t;
  rd_t q0[$];
  rd_t q1[$];
  rd_t e0, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp0(input logic [31:0] d);
    rd_t e;
    e.cyc = cyc + 1;
    e.data = d;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic [31:0] d);
    rd_t e;
    e.cyc = cyc + 1;
    e.data = d;
    q1.push_back(e);
  endtask

  // Monitor: every rvalid must match the next expected return, in its cycle.
  always @(negedge aclk) begin
    if (s0_rvalid === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL s0_rvalid unexpected at cycle %0d", cyc);
      end else begin
        e0 = q0.pop_front();
        chk("s0_rvalid cycle", cyc, e0.cyc);
        chk("s0_rdata", s0_rdata, e0.data);
      end
    end else if (q0.size() > 0 && q0[0].cyc < cyc) begin
      e0 = q0.pop_front();
      checks++; errors++;
      $display("FAIL s0_rvalid missing: due cycle %0d, now %0d", e0.cyc, cyc);
    end
    if (s1_rvalid === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL s1_rvalid unexpected at cycle %0d", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("s1_rvalid cycle", cyc, e1.cyc);
        chk("s1_rdata", s1_rdata, e1.data);
      end
    end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
      e1 = q1.pop_front();
      checks++; errors++;
      $display("FAIL s1_rvalid missing: due cycle %0d, now %0d", e1.cyc, cyc);
    end
  end

  task automatic set0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [WW-1:0] we, input logic lk);
    s0_valid = v; s0_addr = a; s0_wdata = d; s0_we = we; s0_lock = lk;
  endtask

  task automatic set1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [WW-1:0] we, input logic lk);
    s1_valid = v; s1_addr = a; s1_wdata = d; s1_we = we; s1_lock = lk;
  endtask

  task automatic idle_all();
    set0(1'b0, '0, '0, '0, 1'b0);
    set1(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    mem[0] = 32'h1111_1111;
    mem[1] = 32'hA5A5_A5A5;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h3333_3333;
    m_dout = '0;
    aresetn = 1'b0;
    // Requests present during reset must not be accepted.
    set0(1'b1, 4'h4, '0, '0, 1'b0);
    set1(1'b1, 4'h0, '0, '0, 1'b0);
    repeat (2) @(negedge aclk);
    chk("rst s0_ready", s0_ready, 0);
    chk("rst s1_ready", s1_ready, 0);
    chk("rst m_en", m_en, 0);
    chk("rst lock_timeout", lock_timeout, 0);
    chk("rst s0_rvalid", s0_rvalid, 0);
    chk("rst s1_rvalid", s1_rvalid, 0);
    nxt();
    aresetn = 1'b1;
    idle_all();
    nxt();

    // s0 single read of word 1.
    set0(1'b1, 4'h4, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t1 s0_ready", s0_ready, 1);
    chk("t1 m_en", m_en, 1);
    chk("t1 m_addr", m_addr, 4'h4);
    chk("t1 m_we", m_we, 0);
    exp0(32'hA5A5_A5A5);
    nxt();
    idle_all();
    nxt();

    // s1 partial write then read-back of the same word.
    set1(1'b1, 4'h8, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    @(negedge aclk);
    chk("t3 s1_ready wr", s1_ready, 1);
    chk("t3 m_we", m_we, 4'b0011);
    chk("t3 m_din", m_din, 32'hDEAD_BEEF);
    nxt();
    set1(1'b1, 4'h8, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t3 s1_ready rd", s1_ready, 1);
    exp1(32'h0000_BEEF);
    nxt();
    idle_all();
    nxt();

    // Both requesters reading continuously: grants alternate s0,s1,s0,s1.
    for (int i = 0; i < 4; i++) begin
      set0(1'b1, 4'h4, '0, '0, 1'b0);
      set1(1'b1, 4'h0, '0, '0, 1'b0);
      @(negedge aclk);
      if (i % 2 == 0) begin
        chk($sformatf("t2[%0d] s0_ready", i), s0_ready, 1);
        chk($sformatf("t2[%0d] s1_ready", i), s1_ready, 0);
        chk($sformatf("t2[%0d] m_addr", i), m_addr, 4'h4);
        exp0(32'hA5A5_A5A5);
      end else begin
        chk($sformatf("t2[%0d] s0_ready", i), s0_ready, 0);
        chk($sformatf("t2[%0d] s1_ready", i), s1_ready, 1);
        chk($sformatf("t2[%0d] m_addr", i), m_addr, 4'h0);
        exp1(32'h1111_1111);
      end
      nxt();
    end
    idle_all();
    nxt();

    // Lock held by s0 across idle cycles, released by an unlocked write.
    set0(1'b1, 4'hC, '0, '0, 1'b1);
    set1(1'b1, 4'h0, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t4 lock s0_ready", s0_ready, 1);
    chk("t4 lock s1_ready", s1_ready, 0);
    exp0(32'h3333_3333);
    nxt();
    for (int i = 1; i <= 3; i++) begin
      set0(1'b0, '0, '0, '0, 1'b0);
      @(negedge aclk);
      chk($sformatf("t4 idle%0d s1_ready", i), s1_ready, 0);
      chk($sformatf("t4 idle%0d m_en", i), m_en, 0);
      nxt();
    end
    set0(1'b1, 4'hC, 32'h1234_5678, 4'b1111, 1'b0);
    @(negedge aclk);
    chk("t4 unlock s0_ready", s0_ready, 1);
    chk("t4 unlock s1_ready", s1_ready, 0);
    chk("t4 unlock m_we", m_we, 4'b1111);
    nxt();
    set0(1'b0, '0, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t4 after s1_ready", s1_ready, 1);
    exp1(32'h1111_1111);
    nxt();
    idle_all();
    nxt();

    // Watchdog: s0 locks and goes silent; pulse 16 cycles after the lock.
    set0(1'b1, 4'hC, '0, '0, 1'b1);
    set1(1'b1, 4'h0, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t5 lock s0_ready", s0_ready, 1);
    exp0(32'h1234_5678);
    nxt();
    set0(1'b0, '0, '0, '0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      @(negedge aclk);
      chk($sformatf("t5 c%0d lock_timeout", i), lock_timeout, 0);
      chk($sformatf("t5 c%0d s1_ready", i), s1_ready, 0);
      nxt();
    end
    @(negedge aclk);
    chk("t5 c16 lock_timeout", lock_timeout, 1);
    chk("t5 c16 s1_ready", s1_ready, 0);
    chk("t5 c16 m_en", m_en, 0);
    nxt();
    @(negedge aclk);
    chk("t5 c17 lock_timeout", lock_timeout, 0);
    chk("t5 c17 s1_ready", s1_ready, 1);
    exp1(32'h1111_1111);
    nxt();
    idle_all();
    nxt();

    // Reset during a pending read while s1 holds the lock.
    set1(1'b1, 4'h0, '0, '0, 1'b1);
    @(negedge aclk);
    chk("t6 s1 lock ready", s1_ready, 1);
    nxt();
    aresetn = 1'b0;
    set0(1'b1, 4'h4, '0, '0, 1'b0);
    set1(1'b1, 4'h0, '0, '0, 1'b0);
    @(negedge aclk);
    chk("t6 rst s1_rvalid", s1_rvalid, 0);
    chk("t6 rst s0_ready", s0_ready, 0);
    chk("t6 rst s1_ready", s1_ready, 0);
    chk("t6 rst m_en", m_en, 0);
    nxt();
    aresetn = 1'b1;
    nxt();
    @(negedge aclk);
    chk("t6 post s0_ready", s0_ready, 1);
    chk("t6 post s1_ready", s1_ready, 0);
    exp0(32'hA5A5_A5A5);
    nxt();
    idle_all();
    repeat (3) nxt();

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
